// File: rtl/ysyx_22041211_alu_pkg.sv
// Shared op-codes, FSM encodings and divide corner-case constants for the sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_22041211_alu_pkg;

    // Basic single-cycle operations
    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_SLL    = 5'h02;
    localparam logic [4:0] OP_SLT    = 5'h03;
    localparam logic [4:0] OP_SLTU   = 5'h04;
    localparam logic [4:0] OP_XOR    = 5'h05;
    localparam logic [4:0] OP_SRL    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_OR     = 5'h08;
    localparam logic [4:0] OP_AND    = 5'h09;
    localparam logic [4:0] OP_PASS   = 5'h0A;

    // Iterative multiply/divide operations (0x10-0x17)
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    // Sub-codes seen by the mul/div engine: the low three bits of the M op-code
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Divide corner results, sliced down to DATA_LEN by the user
    localparam logic [63:0] DIVZ_QUO = '1;   // quotient on divide by zero
    localparam logic [63:0] OVF_REM  = '0;   // remainder on signed overflow

    // Quotient on signed overflow is the most-negative value of the given width
    function automatic logic [63:0] ovf_quo(input int unsigned width);
        ovf_quo = 64'd1 << (width - 1);
    endfunction

    // True for the eight iterative M op-codes
    function automatic logic is_mop(input logic [4:0] op);
        is_mop = (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/ysyx_22041211_alu_seq_if.sv
// Request/response bundle between an ALU requester (master) and the sequential ALU (slave).
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Signals: in_valid/in_ready, src1, src2, alu_control, flush, out_valid/out_ready, result.
interface ysyx_22041211_alu_seq_if #(
    parameter int DATA_LEN = 32,
    parameter int OP_LEN   = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] src1;
    logic [DATA_LEN-1:0] src2;
    logic [OP_LEN-1:0]   alu_control;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] result;

    modport master (
        output in_valid, src1, src2, alu_control, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, src1, src2, alu_control, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/ysyx_22041211_muldiv_iter.sv
// Radix-2 iterative multiplier/divider on operand magnitudes with a final sign fix-up.
// Latency: exactly DATA_LEN iteration cycles after start_i; last_o marks the final iteration.
// Backpressure: none; registers hold after the last iteration so result_o stays stable until the next start.
// Ports: clk, rst_n, start_i (load operands), flush_i (abort), op_i (M sub-code), src1_i/src2_i, last_o, result_o.
module ysyx_22041211_muldiv_iter
    import ysyx_22041211_alu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                flush_i,
    input  logic [2:0]          op_i,
    input  logic [DATA_LEN-1:0] src1_i,
    input  logic [DATA_LEN-1:0] src2_i,
    output logic                last_o,
    output logic [DATA_LEN-1:0] result_o
);
    localparam int CW = $clog2(DATA_LEN) + 1;
    localparam logic [DATA_LEN-1:0] MOST_NEG = DATA_LEN'(ovf_quo(DATA_LEN));

    logic                busy_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    // Multiply: {hi_q, lo_q} is the product shifting in from the top, lo_q starts as the multiplier.
    // Divide:   hi_q is the partial remainder, lo_q shifts the dividend out and the quotient in.
    logic [DATA_LEN-1:0] hi_q, lo_q, mcand_q;
    logic                neg_q;     // negate product / quotient
    logic                rneg_q;    // negate remainder (sign of dividend)
    logic                div0_q, ovf_q;

    // Operand preparation at start
    logic                s1_signed, s2_signed, a_neg, b_neg, sdiv;
    logic [DATA_LEN-1:0] abs1, abs2;

    always_comb begin
        s1_signed = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) || (op_i == MD_REM);
        s2_signed = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
        sdiv      = (op_i == MD_DIV) || (op_i == MD_REM);
        a_neg     = s1_signed && src1_i[DATA_LEN-1];
        b_neg     = s2_signed && src2_i[DATA_LEN-1];
        // The most-negative value maps onto itself, which is the correct unsigned magnitude
        abs1      = a_neg ? -src1_i : src1_i;
        abs2      = b_neg ? -src2_i : src2_i;
    end

    // One iteration step
    logic [DATA_LEN:0]   mul_sum, div_sh, div_diff;
    logic                div_ge;
    logic [DATA_LEN-1:0] hi_step, lo_step;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        div_sh   = {hi_q, lo_q[DATA_LEN-1]};
        div_diff = div_sh - {1'b0, mcand_q};
        // Partial remainder is always below the divisor, so bit DATA_LEN of the difference is a clean borrow
        div_ge   = ~div_diff[DATA_LEN];
        if (op_q[2]) begin
            hi_step = div_ge ? div_diff[DATA_LEN-1:0] : div_sh[DATA_LEN-1:0];
            lo_step = {lo_q[DATA_LEN-2:0], div_ge};
        end else begin
            hi_step = mul_sum[DATA_LEN:1];
            lo_step = {mul_sum[0], lo_q[DATA_LEN-1:1]};
        end
    end

    assign last_o = busy_q && (cnt_q == CW'(DATA_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (flush_i) begin
            busy_q  <= 1'b0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            op_q    <= op_i;
            hi_q    <= '0;
            lo_q    <= abs1;
            mcand_q <= abs2;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            div0_q  <= op_i[2] && (src2_i == '0);
            ovf_q   <= sdiv && (src1_i == MOST_NEG) && (src2_i == '1);
        end else if (busy_q) begin
            hi_q    <= hi_step;
            lo_q    <= lo_step;
            cnt_q   <= cnt_q + CW'(1);
            if (last_o) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Sign fix-up and corner cases
    logic [2*DATA_LEN-1:0] prod_s;

    always_comb begin
        prod_s   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        result_o = '0;
        case (op_q)
            MD_MUL:                        result_o = lo_q;
            MD_MULH, MD_MULHSU, MD_MULHU:  result_o = prod_s[2*DATA_LEN-1:DATA_LEN];
            MD_DIV, MD_DIVU: begin
                if (div0_q)      result_o = DIVZ_QUO[DATA_LEN-1:0];
                else if (ovf_q)  result_o = MOST_NEG;
                else             result_o = neg_q ? -lo_q : lo_q;
            end
            // Divide by zero leaves |dividend| in hi_q; the dividend-sign fix-up restores src1
            default: begin
                if (ovf_q)       result_o = OVF_REM[DATA_LEN-1:0];
                else             result_o = rneg_q ? -hi_q : hi_q;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_22041211_alu_seq.sv
// Sequential ALU: single-cycle RV basic ops plus iterative RV M-extension multiply/divide.
// Latency: basic/unknown ops 1 cycle after acceptance, M ops DATA_LEN+1 cycles after acceptance.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready; flush aborts.
// Ports: clk, rst_n (async active-low), bus (slave side of ysyx_22041211_alu_seq_if).
module ysyx_22041211_alu_seq
    import ysyx_22041211_alu_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int OP_LEN   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ysyx_22041211_alu_seq_if.slave   bus
);
    state_e              state_q, state_d;
    logic [DATA_LEN-1:0] result_q, result_d;
    logic                is_m_q, is_m_d;    // DONE result comes from the mul/div engine
    logic                md_start, md_last;
    logic [DATA_LEN-1:0] md_result;

    logic [31:0]         op_ext;
    logic                is_m;
    logic [5:0]          shamt;
    logic [DATA_LEN-1:0] basic_res;

    assign op_ext = 32'(bus.alu_control);
    assign is_m   = (op_ext[31:5] == '0) && is_mop(op_ext[4:0]);
    assign shamt  = (DATA_LEN == 64) ? bus.src2[5:0] : {1'b0, bus.src2[4:0]};

    // Basic ops; every unlisted code yields 0
    always_comb begin
        basic_res = '0;
        case (op_ext)
            32'(OP_ADD):  basic_res = bus.src1 + bus.src2;
            32'(OP_SUB):  basic_res = bus.src1 - bus.src2;
            32'(OP_SLL):  basic_res = bus.src1 << shamt;
            32'(OP_SLT):  basic_res = {{(DATA_LEN-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
            32'(OP_SLTU): basic_res = {{(DATA_LEN-1){1'b0}}, (bus.src1 < bus.src2)};
            32'(OP_XOR):  basic_res = bus.src1 ^ bus.src2;
            32'(OP_SRL):  basic_res = bus.src1 >> shamt;
            32'(OP_SRA):  basic_res = DATA_LEN'($signed(bus.src1) >>> shamt);
            32'(OP_OR):   basic_res = bus.src1 | bus.src2;
            32'(OP_AND):  basic_res = bus.src1 & bus.src2;
            32'(OP_PASS): basic_res = bus.src2;
            default:      basic_res = '0;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = is_m_q ? md_result : result_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        is_m_d   = is_m_q;
        md_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_m) begin
                        state_d  = ST_CALC;
                        is_m_d   = 1'b1;
                        md_start = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        is_m_d   = 1'b0;
                        result_d = basic_res;
                    end
                end
            end
            ST_CALC: begin
                if (md_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush wins over everything, including a same-cycle acceptance
        if (bus.flush) begin
            state_d  = ST_IDLE;
            md_start = 1'b0;
            result_d = result_q;
            is_m_d   = is_m_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            is_m_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            is_m_q   <= is_m_d;
        end
    end

    ysyx_22041211_muldiv_iter #(
        .DATA_LEN (DATA_LEN)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .flush_i  (bus.flush),
        .op_i     (bus.alu_control[2:0]),
        .src1_i   (bus.src1),
        .src2_i   (bus.src2),
        .last_o   (md_last),
        .result_o (md_result)
    );

endmodule

// File: doc/ysyx_22041211_alu_seq.md
YSYX_22041211_ALU_SEQ -- requirements
Module: ysyx_22041211_alu_seq

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter OP_LEN, default 5: width of the operation code.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1: the request on src1/src2/alu_control is valid.
REQ-006 SHALL have port in_ready  output  1: the block accepts a request this cycle.
REQ-007 SHALL have port src1  input  DATA_LEN: first operand.
REQ-008 SHALL have port src2  input  DATA_LEN: second operand.
REQ-009 SHALL have port alu_control  input  OP_LEN: operation code.
REQ-010 SHALL have port flush  input  1: synchronous abort of any in-flight operation.
REQ-011 SHALL have port out_valid  output  1: result is valid.
REQ-012 SHALL have port out_ready  input  1: the consumer takes the result this cycle.
REQ-013 SHALL have port result  output  DATA_LEN: operation result.

Function
REQ-014 SHALL accept a request on the rising edge where in_valid and in_ready are both 1, capturing src1, src2 and alu_control.
REQ-015 SHALL drive in_ready=1 only in state IDLE.
REQ-016 SHALL implement a three-state FSM: IDLE, CALC, DONE.
- IDLE->DONE on accepting a basic op.
- IDLE->CALC on accepting an M op.
- CALC->DONE when the iteration counter reaches DATA_LEN.
- DONE->IDLE when out_ready=1.
REQ-017 SHALL implement the basic ops with 1-cycle latency (out_valid on the cycle after acceptance):
- 0x00 add; 0x01 sub; 0x02 sll.
- 0x03 slt (signed); 0x04 sltu.
- 0x05 xor; 0x06 srl; 0x07 sra.
- 0x08 or; 0x09 and; 0x0A pass src2.
REQ-018 SHALL use shift amount src2[4:0] when DATA_LEN=32 and src2[5:0] when DATA_LEN=64.
REQ-019 SHALL make sra an arithmetic (sign-filling) shift.
REQ-020 SHALL implement the M ops:
- 0x10 mul; 0x11 mulh; 0x12 mulhsu; 0x13 mulhu.
- 0x14 div; 0x15 divu; 0x16 rem; 0x17 remu.
REQ-021 SHALL compute the M ops with an iterative radix-2 engine of exactly DATA_LEN CALC cycles, so out_valid rises DATA_LEN+1 cycles after acceptance.
REQ-022 SHALL return the low DATA_LEN bits of the 2*DATA_LEN product for mul, and the high DATA_LEN bits for mulh/mulhsu/mulhu, with the signedness of each operand per RISC-V.
REQ-023 SHALL return, on divide by zero: quotient all-ones, remainder = src1.
REQ-024 SHALL return, on signed overflow (src1 = most-negative value, src2 = -1): quotient = src1, remainder 0.
REQ-025 SHALL truncate the signed quotient toward zero and give the signed remainder the sign of the dividend.
REQ-026 SHALL handle codes in 0x0B-0x0F and 0x18-0x1F in 1 cycle with result 0.
REQ-027 SHALL hold result and out_valid stable in DONE until out_ready=1; result is don't-care while out_valid=0.
REQ-028 SHALL, when flush=1, go to IDLE on the next edge with out_valid=0 and discard the in-flight result; flush overrides acceptance in the same cycle.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state IDLE, out_valid=0, result=0, in_ready=1, iteration counter=0 and internal registers=0.
REQ-030 SHALL abandon an operation interrupted by reset mid-CALC without producing any output.

Structure
REQ-031 SHALL place the op-code constants, FSM state encodings and div-by-zero/overflow result constants in shared package ysyx_22041211_alu_pkg.
REQ-032 SHALL place the iterative multiply/divide datapath (counter, partial product/remainder, sign fix-up) in sub-module ysyx_22041211_muldiv_iter.

Verification
REQ-033 Basic op: sub src1=5, src2=7 -> result 0xFFFFFFFE, out_valid 1 cycle after acceptance.
REQ-034 Signed ops: slt src1=0xFFFFFFFF, src2=1 -> result 1; sra src1=0x80000000, src2=4 -> result 0xF8000000.
REQ-035 Multiply: mulh src1=0x80000000, src2=0x80000000 -> result 0x40000000, out_valid exactly 33 cycles after acceptance.
REQ-036 Divide corners: div x/0 with src1=7 -> 0xFFFFFFFF; rem 7/0 -> 7; div 0x80000000/0xFFFFFFFF -> 0x80000000; rem same operands -> 0.
REQ-037 Backpressure and flush: out_ready=0 for 5 cycles after divu 100/7 -> result 14 held stable, in_ready=0; flush at CALC cycle 10 -> no out_valid, in_ready=1 next cycle.
REQ-038 Reset: rst_n low mid-CALC -> out_valid=0 and in_ready=1 immediately; a new add 1+1 -> result 2.
